cache_lookup_arbiter: RTL and testbench
=======================================

// Module: cache_lookup_arbiter
// PURPOSE
// - Shares one serial tag-lookup path between two requesters: CPU (cpu_*) and bus snoop (snp_*).
// - Arbitrates requests and walks the ways of the indexed set, one way per cycle, through the tag-array read port.
// - Returns hit/miss and way; on a CPU miss, also returns a per-set round-robin victim way.
// - Sits between the processor/snoop front ends and the tag array; the fill and writeback FSMs consume its response.
// PARAMETERS
// - WAYS     8   number of ways per set (power of 2, >=2)
// - WAY_W    3   clog2(WAYS)
// - INDEX_W  4   set-index width (2**INDEX_W sets)
// - TAG_W    12  tag width
// PORTS
// - clk          in   1        clock
// - rstb         in   1        asynchronous, active-low reset
// - cpu_valid    in   1        CPU lookup request
// - cpu_ready    out  1        CPU request accepted this cycle
// - cpu_index    in   INDEX_W  CPU set index
// - cpu_tag      in   TAG_W    CPU tag
// - snp_valid    in   1        snoop lookup request
// - snp_ready    out  1        snoop request accepted this cycle
// - snp_index    in   INDEX_W  snoop set index
// - snp_tag      in   TAG_W    snoop tag
// - ta_index     out  INDEX_W  tag-array set select
// - ta_way       out  WAY_W    tag-array way select
// - ta_tag       in   TAG_W    tag at {ta_index, ta_way}, combinational same cycle
// - ta_valid     in   1        valid bit at {ta_index, ta_way}
// - rsp_valid    out  1        response available
// - rsp_ready    in   1        response consumed
// - rsp_hit      out  1        1 = hit, 0 = miss
// - rsp_way      out  WAY_W    hit way, or victim way on a CPU miss
// - rsp_src      out  1        0 = CPU, 1 = snoop
// BEHAVIOUR
// - FSM states: IDLE, SEARCH, RESP. Reset puts the FSM in IDLE.
// - Reset values: all outputs 0, all victim pointers 0, way counter 0.
// - Arbitration (IDLE only):
//   - Snoop has fixed priority. When both are valid, snp_ready=1 and cpu_ready=0.
//   - Ready signals are combinational from valid and state; they are 0 outside IDLE.
//   - On accept, latch index, tag and src; clear way counter; go to SEARCH.
// - SEARCH: ta_index = latched index, ta_way = counter. Each cycle:
//   - If ta_valid && ta_tag == latched tag: register hit=1, way=counter; go to RESP.
//   - Else if counter == WAYS-1: register hit=0; go to RESP.
//     - CPU miss: way = victim_ptr[index], and victim_ptr[index] increments, wrapping WAYS-1 -> 0.
//     - Snoop miss: way = 0; the pointer is not changed (snoops never allocate).
//   - Else: counter + 1.
// - Latency: accept in cycle N.
//   - Hit in way k: rsp_valid rises in cycle N+2+k.
//   - Miss: rsp_valid rises in cycle N+1+WAYS.
// - RESP: rsp_valid=1, and rsp_* is held stable until rsp_ready=1. Then go to IDLE.
//   - A new accept is possible in the following cycle; there is no same-cycle accept.
// - Duplicate tag match (error case): the lowest matching way is reported, because the search stops at the first match.
// - Invalid entries whose stale tag matches are never a hit.
// - ta_index/ta_way: 0 outside SEARCH.
// - Reset mid-operation: the request is dropped, the FSM goes to IDLE, and no response is issued.
// CONFIGURATION
// - CACHE_LOOKUP_STATS_EN defined:
//   - Adds outputs stat_hits[15:0] and stat_misses[15:0], reset to 0.
//   - Each increments by 1 on the RESP->IDLE handshake, by outcome; both requesters are counted.
//   - Counters saturate at 16'hFFFF.
// - Not defined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
// - Test 1: CPU idx=3 tag=0xABC, way 5 valid with 0xABC, WAYS=8
//   -> rsp_valid at N+7, hit=1, way=5, src=0.
// - Test 2: CPU idx=2, no match, victim_ptr[2]=7
//   -> rsp at N+9, hit=0, way=7, victim_ptr[2] becomes 0.
//   - Repeat the miss -> way=0.
// - Test 3: cpu_valid and snp_valid rise together
//   -> snoop accepted first (src=1), CPU accepted the cycle after the snoop response handshake.
// - Test 4: snoop miss on idx=2 -> hit=0, way=0, victim_ptr[2] unchanged.
// - Test 5: way 1 holds the matching tag with valid=0 and way 4 holds it with valid=1 -> hit=1, way=4.
// - Test 6: hold rsp_ready=0 for 5 cycles -> rsp_* stable, both readys 0.
// - Test 7: assert rstb=0 during SEARCH -> all outputs 0 immediately, IDLE after release.
// - Test 8 (CACHE_LOOKUP_STATS_EN): 3 hits + 2 misses -> stat_hits=3, stat_misses=2.

Source files
------------

// File: rtl/cache_lookup_arbiter.sv
// cache_lookup_arbiter: snoop/CPU arbiter over a serial, one-way-per-cycle
// tag-lookup walk, with a per-set round-robin victim pointer for CPU misses.
// Ports: clk, rstb (async, active-low)
//   cpu_valid/cpu_ready/cpu_index/cpu_tag  CPU lookup request
//   snp_valid/snp_ready/snp_index/snp_tag  snoop lookup request (priority)
//   ta_index/ta_way -> ta_tag/ta_valid     tag-array read port
//   rsp_valid/rsp_ready/rsp_hit/rsp_way/rsp_src  lookup response
// Optional: CACHE_LOOKUP_STATS_EN adds stat_hits/stat_misses counters.
module cache_lookup_arbiter #(
  parameter int WAYS    = 8,
  parameter int WAY_W   = 3,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 12
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic [INDEX_W-1:0] cpu_index,
  input  logic [TAG_W-1:0]   cpu_tag,
  input  logic               snp_valid,
  output logic               snp_ready,
  input  logic [INDEX_W-1:0] snp_index,
  input  logic [TAG_W-1:0]   snp_tag,
  output logic [INDEX_W-1:0] ta_index,
  output logic [WAY_W-1:0]   ta_way,
  input  logic [TAG_W-1:0]   ta_tag,
  input  logic               ta_valid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic [WAY_W-1:0]   rsp_way,
`ifdef CACHE_LOOKUP_STATS_EN
  output logic               rsp_src,
  output logic [15:0]        stat_hits,
  output logic [15:0]        stat_misses
`else
  output logic               rsp_src
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } state_t;

  localparam int SETS = 2 ** INDEX_W;

  state_t             st, nx;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               src_q;
  logic [WAY_W-1:0]   cnt_q;
  logic               hit_q;
  logic [WAY_W-1:0]   way_q;
  logic [WAY_W-1:0]   vptr [SETS];

  logic match, last;
  logic take_snp, take_cpu;

  assign match    = ta_valid && (ta_tag == tag_q);
  assign last     = cnt_q == WAY_W'(WAYS - 1);
  assign take_snp = (st == IDLE) && snp_valid;
  assign take_cpu = (st == IDLE) && cpu_valid && !snp_valid;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) st <= IDLE;
    else       st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      IDLE:    if (snp_valid || cpu_valid) nx = SEARCH;
      SEARCH:  if (match || last) nx = RESP;
      RESP:    if (rsp_ready) nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    snp_ready = 1'b0;
    ta_index  = '0;
    ta_way    = '0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    rsp_way   = '0;
    rsp_src   = 1'b0;
    unique case (1'b1)
      st == IDLE: begin
        snp_ready = snp_valid;
        cpu_ready = cpu_valid && !snp_valid;
      end
      st == SEARCH: begin
        ta_index = idx_q;
        ta_way   = cnt_q;
      end
      st == RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_way   = way_q;
        rsp_src   = src_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx_q <= '0;
      tag_q <= '0;
      src_q <= 1'b0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      way_q <= '0;
      for (int i = 0; i < SETS; i++) vptr[i] <= '0;
    end else if (take_snp || take_cpu) begin
      idx_q <= take_snp ? snp_index : cpu_index;
      tag_q <= take_snp ? snp_tag : cpu_tag;
      src_q <= take_snp;
      cnt_q <= '0;
    end else if (st == SEARCH) begin
      if (match) begin
        hit_q <= 1'b1;
        way_q <= cnt_q;
      end else if (last) begin
        hit_q <= 1'b0;
        // Only CPU misses allocate; snoops report way 0.
        if (!src_q) begin
          way_q       <= vptr[idx_q];
          vptr[idx_q] <= vptr[idx_q] + WAY_W'(1);
        end else begin
          way_q <= '0;
        end
      end else begin
        cnt_q <= cnt_q + WAY_W'(1);
      end
    end
  end

`ifdef CACHE_LOOKUP_STATS_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (st == RESP && rsp_ready) begin
      if (hit_q && stat_hits != 16'hFFFF)
        stat_hits <= stat_hits + 16'd1;
      if (!hit_q && stat_misses != 16'hFFFF)
        stat_misses <= stat_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_lookup_arbiter.sv
// tb_cache_lookup_arbiter: directed bench for cache_lookup_arbiter
// with a behavioural tag array and hand-computed expectations.
module tb_cache_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cpu_valid, cpu_ready;
  logic [3:0]  cpu_index;
  logic [11:0] cpu_tag;
  logic        snp_valid, snp_ready;
  logic [3:0]  snp_index;
  logic [11:0] snp_tag;
  logic [3:0]  ta_index;
  logic [2:0]  ta_way;
  logic [11:0] ta_tag;
  logic        ta_valid;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_src;
  logic [2:0]  rsp_way;
`ifdef CACHE_LOOKUP_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  logic [11:0] tmem [16][8];
  logic        vmem [16][8];

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic saw;

  always #5 clk = ~clk;

  always_comb begin
    ta_tag   = tmem[ta_index][ta_way];
    ta_valid = vmem[ta_index][ta_way];
  end

  cache_lookup_arbiter dut (
    .clk(clk), .rstb(rstb),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_index(cpu_index), .cpu_tag(cpu_tag),
    .snp_valid(snp_valid), .snp_ready(snp_ready),
    .snp_index(snp_index), .snp_tag(snp_tag),
    .ta_index(ta_index), .ta_way(ta_way),
    .ta_tag(ta_tag), .ta_valid(ta_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way),
`ifdef CACHE_LOOKUP_STATS_EN
    .rsp_src(rsp_src),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
`else
    .rsp_src(rsp_src)
`endif
  );

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic wait_resp(output int l);
    l = 1;
    while (rsp_valid !== 1'b1 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  // Call at #1 after an edge with the DUT in IDLE.
  task automatic lookup(input logic s, input logic [3:0] i,
                        input logic [11:0] t, output int l);
    if (s) begin
      snp_valid = 1'b1; snp_index = i; snp_tag = t;
    end else begin
      cpu_valid = 1'b1; cpu_index = i; cpu_tag = t;
    end
    @(posedge clk); #1;
    snp_valid = 1'b0;
    cpu_valid = 1'b0;
    wait_resp(l);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++) begin
        tmem[i][j] = 12'hF00 + 12'(j);
        vmem[i][j] = 1'b1;
      end
    for (int j = 0; j < 8; j++) begin
      tmem[3][j] = 12'h100 + 12'(j);
      tmem[2][j] = 12'h200 + 12'(j);
    end
    tmem[3][5] = 12'hABC;
    tmem[5][1] = 12'h555; vmem[5][1] = 1'b0;
    tmem[5][4] = 12'h555;
    tmem[6][2] = 12'h666;
    tmem[6][6] = 12'h666;

    rstb = 1'b0;
    cpu_valid = 0; cpu_index = 0; cpu_tag = 0;
    snp_valid = 0; snp_index = 0; snp_tag = 0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs",
        {rsp_valid, rsp_hit, rsp_way, rsp_src, ta_index, ta_way,
         cpu_ready, snp_ready}, 0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Test 1: hit way 5
    lookup(1'b0, 4'd3, 12'hABC, lat);
    chk("t1_lat", lat, 7);
    chk("t1_rsp", {rsp_hit, rsp_way, rsp_src}, {1'b1, 3'd5, 1'b0});
    ack();

    // Boundary hits: way 0 and way 7
    lookup(1'b0, 4'd3, 12'h100, lat);
    chk("hit_w0_lat", lat, 2);
    chk("hit_w0_rsp", {rsp_hit, rsp_way}, {1'b1, 3'd0});
    ack();
    lookup(1'b0, 4'd3, 12'h107, lat);
    chk("hit_w7_lat", lat, 9);
    chk("hit_w7_rsp", {rsp_hit, rsp_way}, {1'b1, 3'd7});
    ack();

    // Test 2: walk victim pointer of set 2 through 0..7, then wrap
    for (int w = 0; w < 8; w++) begin
      lookup(1'b0, 4'd2, 12'h999, lat);
      chk("t2_lat", lat, 9);
      chk("t2_victim", {rsp_hit, rsp_way, rsp_src}, {1'b0, 3'(w), 1'b0});
      ack();
    end
    lookup(1'b0, 4'd2, 12'h999, lat);
    chk("t2_wrap", {rsp_hit, rsp_way}, {1'b0, 3'd0});
    ack();

    // Test 4: snoop miss reports way 0, pointer (now 1) untouched
    lookup(1'b1, 4'd2, 12'h999, lat);
    chk("t4_lat", lat, 9);
    chk("t4_rsp", {rsp_hit, rsp_way, rsp_src}, {1'b0, 3'd0, 1'b1});
    ack();
    lookup(1'b0, 4'd2, 12'h999, lat);
    chk("t4_ptr", {rsp_hit, rsp_way}, {1'b0, 3'd1});
    ack();

    // Test 3: simultaneous requests, snoop first
    snp_valid = 1'b1; snp_index = 4'd3; snp_tag = 12'hABC;
    cpu_valid = 1'b1; cpu_index = 4'd3; cpu_tag = 12'h101;
    #1;
    chk("t3_ready", {snp_ready, cpu_ready}, 2'b10);
    @(posedge clk); #1;
    snp_valid = 1'b0;
    chk("t3_busy", {snp_ready, cpu_ready}, 2'b00);
    wait_resp(lat);
    chk("t3_snp", {rsp_hit, rsp_way, rsp_src}, {1'b1, 3'd5, 1'b1});
    chk("t3_resp_busy", cpu_ready, 1'b0);
    ack();
    chk("t3_cpu_ready", cpu_ready, 1'b1);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    wait_resp(lat);
    chk("t3_cpu_lat", lat, 3);
    chk("t3_cpu", {rsp_hit, rsp_way, rsp_src}, {1'b1, 3'd1, 1'b0});
    ack();

    // Test 5: stale invalid match skipped
    lookup(1'b0, 4'd5, 12'h555, lat);
    chk("t5_lat", lat, 6);
    chk("t5_rsp", {rsp_hit, rsp_way}, {1'b1, 3'd4});

    // Test 6: hold response with both requesters pending
    cpu_valid = 1'b1; snp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t6_hold",
          {rsp_valid, rsp_hit, rsp_way, rsp_src, cpu_ready, snp_ready},
          {1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0});
    end
    cpu_valid = 1'b0; snp_valid = 1'b0;
    ack();

    // Duplicate tags: lowest way wins
    lookup(1'b0, 4'd6, 12'h666, lat);
    chk("dup_rsp", {rsp_hit, rsp_way, lat[3:0]}, {1'b1, 3'd2, 4'd4});
    ack();

    // Test 7: reset during SEARCH
    cpu_valid = 1'b1; cpu_index = 4'd2; cpu_tag = 12'h999;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    chk("t7_search", {ta_index, ta_way}, {4'd2, 3'd1});
    rstb = 1'b0;
    #1;
    chk("t7_reset_outs",
        {rsp_valid, rsp_hit, rsp_way, rsp_src, ta_index, ta_way,
         cpu_ready, snp_ready}, 0);
    @(posedge clk); #1;
    rstb = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || ta_way !== 3'd0) saw = 1'b1;
    end
    chk("t7_dropped", saw, 1'b0);
`ifdef CACHE_LOOKUP_STATS_EN
    chk("t8_reset", {stat_hits, stat_misses}, 0);
`endif
    // Victim pointers restart at 0
    lookup(1'b0, 4'd2, 12'h999, lat);
    chk("t7_ptr_reset", {rsp_hit, rsp_way, lat[3:0]}, {1'b0, 3'd0, 4'd9});
    ack();

    // Test 8 traffic: 2 misses total (one above) and 3 hits
    lookup(1'b1, 4'd2, 12'h999, lat);
    ack();
    lookup(1'b0, 4'd3, 12'hABC, lat);
    ack();
    lookup(1'b1, 4'd5, 12'h555, lat);
    ack();
    lookup(1'b0, 4'd6, 12'h666, lat);
    chk("t8_last", {rsp_hit, rsp_way}, {1'b1, 3'd2});
    ack();
`ifdef CACHE_LOOKUP_STATS_EN
    chk("t8_stats", {stat_hits, stat_misses}, {16'd3, 16'd2});
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
